// File: rtl/ball_pkg.sv
// Shared types and widths for the bouncing-ball motion controller.
package ball_pkg;

  localparam int POS_W  = 10;
  localparam int VEL_W  = 4;
  localparam int CALC_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    STEP_X,
    STEP_Y,
    COMMIT
  } ball_state_t;

endpackage

// File: rtl/ball_axis_step.sv
// One-axis position step with reflection off the 0 and lim borders.
// Purely combinational; shared between the X and Y axes by the controller.
module ball_axis_step
  import ball_pkg::*;
(
  input  logic        [POS_W-1:0] p,
  input  logic signed [VEL_W-1:0] v,
  input  logic        [POS_W-1:0] lim,
  output logic        [POS_W-1:0] p_next,
  output logic signed [VEL_W-1:0] v_next,
  output logic                    hit
);

  logic signed [CALC_W-1:0] sum;
  logic signed [CALC_W-1:0] lim_s;

  always_comb begin
    sum    = $signed({1'b0, p}) + $signed({{(CALC_W-VEL_W){v[VEL_W-1]}}, v});
    lim_s  = $signed({1'b0, lim});
    p_next = sum[POS_W-1:0];
    v_next = v;
    hit    = 1'b0;
    // A zero velocity satisfies neither branch, so it never bounces.
    if (v > 0 && sum > lim_s) begin
      p_next = lim;
      v_next = -v;
      hit    = 1'b1;
    end else if (v < 0 && sum < 0) begin
      p_next = '0;
      v_next = -v;
      hit    = 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Frame-rate ball motion controller: one step per rising vsync, X then Y
// through a shared axis-step unit. Optional bounce counter: BALL_HIT_CNT_EN.
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BALL_SIZE = 4,
  parameter int X_INIT    = 128,
  parameter int Y_INIT    = 128,
  parameter int VX_INIT   = 2,
  parameter int VY_INIT   = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vsync,
  input  logic             i_run,
  input  logic             i_serve,
  output logic [POS_W-1:0] o_ball_x,
  output logic [POS_W-1:0] o_ball_y,
  output logic             o_update,
  output logic             o_busy
`ifdef BALL_HIT_CNT_EN
  ,
  output logic [7:0]       o_hit_count
`endif
);

  localparam logic        [POS_W-1:0] X0    = POS_W'(X_INIT);
  localparam logic        [POS_W-1:0] Y0    = POS_W'(Y_INIT);
  localparam logic signed [VEL_W-1:0] VX0   = VEL_W'(VX_INIT);
  localparam logic signed [VEL_W-1:0] VY0   = VEL_W'(VY_INIT);
  localparam logic        [POS_W-1:0] X_LIM = POS_W'(H_ACTIVE - BALL_SIZE);
  localparam logic        [POS_W-1:0] Y_LIM = POS_W'(V_ACTIVE - BALL_SIZE);

  ball_state_t state, next_state;
  logic        vsync_q;
  logic        tick;

  logic signed [VEL_W-1:0] vx, vy, nvx, nvy;
  logic        [POS_W-1:0] nx, ny;

  logic        [POS_W-1:0] step_p, step_lim, step_p_next;
  logic signed [VEL_W-1:0] step_v, step_v_next;
  logic                    step_hit;

  assign tick = i_vsync & ~vsync_q & i_run;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tick) next_state = STEP_X;
      STEP_X:  next_state = STEP_Y;
      STEP_Y:  next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Serve overrides everything, including a coincident tick.
    if (i_serve) next_state = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      vsync_q  <= 1'b0;
      o_busy   <= 1'b0;
      o_update <= 1'b0;
    end else begin
      state    <= next_state;
      vsync_q  <= i_vsync;
      o_busy   <= (next_state != IDLE);
      o_update <= i_serve | (state == COMMIT);
    end
  end

  always_comb begin
    step_p   = o_ball_x;
    step_v   = vx;
    step_lim = X_LIM;
    if (state == STEP_Y) begin
      step_p   = o_ball_y;
      step_v   = vy;
      step_lim = Y_LIM;
    end
  end

  ball_axis_step u_step (
    .p      (step_p),
    .v      (step_v),
    .lim    (step_lim),
    .p_next (step_p_next),
    .v_next (step_v_next),
    .hit    (step_hit)
  );

  // Step results land in the next-state registers; COMMIT publishes them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ball_x <= X0;
      o_ball_y <= Y0;
      vx       <= VX0;
      vy       <= VY0;
      nx       <= X0;
      ny       <= Y0;
      nvx      <= VX0;
      nvy      <= VY0;
    end else if (i_serve) begin
      o_ball_x <= X0;
      o_ball_y <= Y0;
      vx       <= VX0;
      vy       <= VY0;
      nx       <= X0;
      ny       <= Y0;
      nvx      <= VX0;
      nvy      <= VY0;
    end else begin
      case (state)
        STEP_X: begin
          nx  <= step_p_next;
          nvx <= step_v_next;
        end
        STEP_Y: begin
          ny  <= step_p_next;
          nvy <= step_v_next;
        end
        COMMIT: begin
          o_ball_x <= nx;
          o_ball_y <= ny;
          vx       <= nvx;
          vy       <= nvy;
        end
        default: ;
      endcase
    end
  end

`ifdef BALL_HIT_CNT_EN
  logic       hit_x, hit_y;
  logic [7:0] hit_count;

  // X and Y hits in one frame are merged into a single count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_x     <= 1'b0;
      hit_y     <= 1'b0;
      hit_count <= '0;
    end else if (i_serve) begin
      hit_x     <= 1'b0;
      hit_y     <= 1'b0;
      hit_count <= '0;
    end else begin
      if (state == STEP_X) hit_x <= step_hit;
      if (state == STEP_Y) hit_y <= step_hit;
      if (state == COMMIT && (hit_x | hit_y) && hit_count != 8'hFF)
        hit_count <= hit_count + 8'd1;
    end
  end

  assign o_hit_count = hit_count;
`else
  logic unused_hit;
  assign unused_hit = step_hit;
`endif

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: vector table, corner-case
// sequences and randomized traffic against a frame-level reference model.
module tb_ball_motion_ctrl;

  logic clk;
  logic rst_n;
  logic vsync;
  logic run;
  logic serve;

  logic [9:0] ax, ay, bx, by, cx, cy;
  logic       upd_a, upd_b, upd_c;
  logic       busy_a, busy_b, busy_c;
`ifdef BALL_HIT_CNT_EN
  logic [7:0] hc_a, hc_b, hc_c;
`endif

  int checks;
  int passed;
  int upd_cnt;
  int busy_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ball_motion_ctrl dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_run(run), .i_serve(serve),
    .o_ball_x(ax), .o_ball_y(ay), .o_update(upd_a), .o_busy(busy_a)
`ifdef BALL_HIT_CNT_EN
    , .o_hit_count(hc_a)
`endif
  );

  ball_motion_ctrl #(.X_INIT(634)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_run(run), .i_serve(serve),
    .o_ball_x(bx), .o_ball_y(by), .o_update(upd_b), .o_busy(busy_b)
`ifdef BALL_HIT_CNT_EN
    , .o_hit_count(hc_b)
`endif
  );

  ball_motion_ctrl #(.Y_INIT(1), .VY_INIT(-2)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_run(run), .i_serve(serve),
    .o_ball_x(cx), .o_ball_y(cy), .o_update(upd_c), .o_busy(busy_c)
`ifdef BALL_HIT_CNT_EN
    , .o_hit_count(hc_c)
`endif
  );

  always @(negedge clk) begin
    if (upd_a) upd_cnt++;
    if (busy_a) busy_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic pulse_serve();
    @(posedge clk); #1 serve = 1'b1;
    @(posedge clk); #1 serve = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic frame(input logic run_v);
    @(posedge clk); #1 run = run_v; vsync = 1'b1;
    repeat (6) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Expects dut_a at 128/128 with vsync low and its delayed copy low.
  task automatic latency_check(input string tag);
    int b0;
    @(posedge clk); #1 vsync = 1'b1; run = 1'b1;
    b0 = busy_cnt;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 3) check({tag, " upd before commit"}, int'(upd_a), 0);
      if (j == 4) begin
        check({tag, " upd pulse"}, int'(upd_a), 1);
        check({tag, " x"}, int'(ax), 130);
        check({tag, " y"}, int'(ay), 130);
      end
      if (j == 5) check({tag, " upd single"}, int'(upd_a), 0);
    end
    check({tag, " busy cycles"}, busy_cnt - b0, 3);
    #1 vsync = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Reference model: one frame step per accepted tick, published three
  // cycles after acceptance; ticks during that window are lost.
  int m_x, m_y, m_vx, m_vy, m_phase, m_prev;
  int m_upd, m_busy;

  task automatic axis(inout int p, inout int v, input int lim);
    int s;
    s = p + v;
    if (v > 0 && s > lim) begin p = lim; v = -v; end
    else if (v < 0 && s < 0) begin p = 0; v = -v; end
    else p = s;
  endtask

  task automatic model_edge(input logic vs, input logic rn, input logic sv);
    logic tk;
    tk = vs && (m_prev == 0) && rn;
    if (sv) begin
      m_x = 128; m_y = 128; m_vx = 2; m_vy = 2;
      m_phase = 0; m_upd = 1;
    end else begin
      m_upd = 0;
      if (m_phase == 0) begin
        if (tk) m_phase = 1;
      end else if (m_phase < 3) begin
        m_phase++;
      end else begin
        axis(m_x, m_vx, 636);
        axis(m_y, m_vy, 476);
        m_phase = 0;
        m_upd = 1;
      end
    end
    m_busy = (m_phase != 0);
    m_prev = int'(vs);
  endtask

  typedef struct {
    logic serve;
    logic run;
    int   ticks;
    int   exp_x;
    int   exp_y;
    int   exp_upd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    checks = 0; passed = 0; upd_cnt = 0; busy_cnt = 0;
    vecs[0] = '{1'b1, 1'b1, 1, 130, 130, 1};
    vecs[1] = '{1'b0, 1'b1, 2, 134, 134, 2};
    vecs[2] = '{1'b0, 1'b0, 5, 134, 134, 0};
    vecs[3] = '{1'b1, 1'b1, 0, 128, 128, 0};
    vecs[4] = '{1'b1, 1'b0, 5, 128, 128, 0};
    vecs[5] = '{1'b0, 1'b1, 3, 134, 134, 3};

    rst_n = 1'b0; vsync = 1'b0; run = 1'b0; serve = 1'b0;
    #12;
    check("reset x", int'(ax), 128);
    check("reset y", int'(ay), 128);
    check("reset update", int'(upd_a), 0);
    check("reset busy", int'(busy_a), 0);
`ifdef BALL_HIT_CNT_EN
    check("reset hit count", int'(hc_a), 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    latency_check("first tick");

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].serve) pulse_serve();
      base = upd_cnt;
      for (int t = 0; t < vecs[i].ticks; t++) frame(vecs[i].run);
      @(negedge clk);
      check($sformatf("vec%0d x", i), int'(ax), vecs[i].exp_x);
      check($sformatf("vec%0d y", i), int'(ay), vecs[i].exp_y);
      check($sformatf("vec%0d updates", i), upd_cnt - base, vecs[i].exp_upd);
    end

    // Right-border reflection on dut_b, top-border reflection on dut_c.
    pulse_serve();
    frame(1'b1);
    @(negedge clk);
    check("right edge x tick1", int'(bx), 636);
    check("top edge y tick1", int'(cy), 0);
    frame(1'b1);
    @(negedge clk);
    check("right edge x tick2", int'(bx), 636);
    check("top edge y tick2", int'(cy), 2);
    frame(1'b1);
    @(negedge clk);
    check("right edge x tick3", int'(bx), 634);
    check("top edge y tick3", int'(cy), 4);
`ifdef BALL_HIT_CNT_EN
    check("hit count right", int'(hc_b), 1);
    check("hit count top", int'(hc_c), 1);
    check("hit count none", int'(hc_a), 0);
`endif

    // Serve coinciding with a tick.
    pulse_serve();
    frame(1'b1);
    @(posedge clk); #1 vsync = 1'b1; serve = 1'b1; run = 1'b1;
    base = upd_cnt;
    @(posedge clk); #1 serve = 1'b0;
    @(negedge clk);
    check("serve+tick x", int'(ax), 128);
    check("serve+tick busy", int'(busy_a), 0);
    repeat (7) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("serve+tick updates", upd_cnt - base, 1);
    check("serve+tick final x", int'(ax), 128);
    check("serve+tick final y", int'(ay), 128);

    // Serve while the shared unit is on the Y axis.
    frame(1'b1);
    @(posedge clk); #1 vsync = 1'b1;
    base = upd_cnt;
    @(posedge clk);
    @(posedge clk); #1 serve = 1'b1;
    @(posedge clk); #1 serve = 1'b0;
    repeat (5) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("serve in step_y updates", upd_cnt - base, 1);
    check("serve in step_y x", int'(ax), 128);
    check("serve in step_y y", int'(ay), 128);

    // Asynchronous reset in the middle of a step.
    frame(1'b1);
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async reset x", int'(ax), 128);
    check("async reset y", int'(ay), 128);
    check("async reset busy", int'(busy_a), 0);
    check("async reset update", int'(upd_a), 0);
    vsync = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    latency_check("after reset");

    // Randomized traffic against the reference model.
    pulse_serve();
    @(negedge clk);
    m_x = 128; m_y = 128; m_vx = 2; m_vy = 2;
    m_phase = 0; m_prev = 0; m_upd = 0; m_busy = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) vsync = ~vsync;
      if ($urandom_range(40) == 0) run = ~run;
      serve = ($urandom_range(80) == 0);
      @(posedge clk);
      model_edge(vsync, run, serve);
      @(negedge clk);
      check("rand x", int'(ax), m_x);
      check("rand y", int'(ay), m_y);
      check("rand update", int'(upd_a), m_upd);
      check("rand busy", int'(busy_a), m_busy);
    end
    serve = 1'b0; vsync = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ball_motion_ctrl.md
# ball_motion_ctrl

Frame-rate motion controller for the bouncing-ball demo. It detects the start of each vertical sync pulse and steps the ball one frame. The X and Y axes are updated in sequence through a single shared axis-step datapath, with reflection off the visible-area borders. It feeds registered ball coordinates to the pixel renderer, sits beside `video_sync_generator`, and takes its `o_vsync` as the frame tick.

## Interface
- `H_ACTIVE`, 640: visible width in pixels.
- `V_ACTIVE`, 480: visible height in pixels.
- `BALL_SIZE`, 4: ball edge length in pixels.
- `X_INIT`, 128: position loaded on reset or serve.
- `Y_INIT`, 128: position loaded on reset or serve.
- `VX_INIT`, +2: signed 4-bit velocity loaded on reset or serve.
- `VY_INIT`, +2: signed 4-bit velocity loaded on reset or serve.
- `i_clk`  in  1  pixel clock; the only clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_vsync`  in  1  vsync from the sync generator, synchronous to `i_clk`.
- `i_run`  in  1  when 0, frame ticks are ignored and the ball is frozen.
- `i_serve`  in  1  one-cycle pulse that reloads the init position and velocity.
- `o_ball_x`  out  10  ball left edge.
- `o_ball_y`  out  10  ball top edge.
- `o_update`  out  1  one-cycle pulse when new coordinates are committed.
- `o_busy`  out  1  high while the FSM is not in IDLE.
- `o_hit_count`  out  8  bounce counter; present only with `BALL_HIT_CNT_EN`.

## Operation
- Tick detection: `vsync_q` holds `i_vsync` delayed by one cycle. `tick = i_vsync & ~vsync_q & i_run`.
- FSM states: IDLE, STEP_X, STEP_Y, COMMIT.
  - IDLE: on `tick`, go to STEP_X; otherwise stay.
  - STEP_X: the shared step unit processes (x, vx). Results go to `nx`, `nvx`. Go to STEP_Y.
  - STEP_Y: the same unit processes (y, vy) with limit `V_ACTIVE-BALL_SIZE`. Results go to `ny`, `nvy`. Go to COMMIT.
  - COMMIT: copy `nx`, `ny`, `nvx`, `nvy` into the architectural registers and pulse `o_update`. Go to IDLE.
- Axis step arithmetic (11-bit signed): `s = p + v`, with `lim = ACTIVE - BALL_SIZE`.
  - If `v > 0` and `s > lim`: `p' = lim`, `v' = -v`, and a hit is flagged.
  - If `v < 0` and `s < 0`: `p' = 0`, `v' = -v`, and a hit is flagged.
  - Otherwise: `p' = s[9:0]`, `v' = v`.
  - `v = 0` never bounces.
- Serve: `i_serve` in any state forces IDLE. It loads the init values into both the architectural and next registers, pulses `o_update` in the next cycle, and discards any in-flight step.
- Simultaneous serve and tick: serve wins and the tick is dropped.
- Tick outside IDLE: dropped, with no queueing.
- `i_run` falling mid-sequence: the sequence completes normally.

## Timing
- Reset values: `o_ball_x = X_INIT`, `o_ball_y = Y_INIT`, velocities at init, `o_update = 0`, `o_busy = 0`, `o_hit_count = 0`, state IDLE, `vsync_q = 0`.
- Latency: a rising `i_vsync` sampled at edge N gives FSM STEP_X at N+1, STEP_Y at N+2, COMMIT at N+3. `o_update` is high and new coordinates are visible after edge N+4.
- `o_busy` is high for exactly 3 cycles per tick.
- All outputs are registered.
- Reset asserted mid-sequence aborts immediately, with no partial commit.

## Configuration
- `BALL_HIT_CNT_EN` defined:
  - `o_hit_count` port exists.
  - It increments by 1 at COMMIT per frame with at least one axis hit; X and Y hitting in the same frame count as 1.
  - It saturates at 255 and is cleared by reset or serve.
- `BALL_HIT_CNT_EN` undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Package `ball_pkg` holds:
  - the state typedef `ball_state_t` (IDLE/STEP_X/STEP_Y/COMMIT);
  - `POS_W = 10`, `VEL_W = 4`, `CALC_W = 11`.
- Sub-module `ball_axis_step`: purely combinational, with inputs `p`, `v`, `lim` and outputs `p'`, `v'`, `hit`. It is instantiated once and time-multiplexed by the FSM between the X and Y axes; its inputs are muxed on state.

## Test plan
- Reset, then one vsync rising edge with `i_run = 1`: `o_update` pulses 4 cycles after the edge, with x = 130 and y = 130. `o_busy` is high for 3 cycles.
- `X_INIT = 634`, `VX_INIT = +2`, two ticks: first x = 636 (no bounce), second x = 636 with vx = -2; third tick gives x = 634. The hit count is 1 when `BALL_HIT_CNT_EN` is defined.
- `Y_INIT = 1`, `VY_INIT = -2`, one tick: y = 0 and vy = +2; next tick y = 2.
- `i_run = 0` over 5 vsync edges: no `o_update`, and coordinates stay at 128/128.
- `i_serve` in the same cycle as a tick, and separately `i_serve` during STEP_Y: both return to IDLE with x = 128 and y = 128. There is exactly one `o_update` pulse, the cycle after serve, and no stale commit.
- Deassert `i_rst_n` during STEP_X: outputs go to reset values asynchronously, and the next tick after release behaves as in scenario 1.
